// File: rtl/regfile_wb_scheduler_if.sv
// Write-back bus between the execute/memory producers, the issue stage and the
// register-file write port.
//   a_*   : ALU write-back request (valid/ready handshake, rd, data)
//   b_*   : load write-back request (valid/ready handshake, rd, data)
//   iss_* : issuing instruction's destination register (marks it busy)
//   busy  : per-register pending write-back scoreboard
//   reg_write/rw_reg/wr_data : registered register-file write port
// slave modport is taken by the scheduler, master by whoever drives the requests.
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [NREG-1:0]   busy;
  logic              reg_write;
  logic [ADDR_W-1:0] rw_reg;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  iss_valid, iss_rd,
    output a_ready, b_ready,
    output busy, reg_write, rw_reg, wr_data
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output iss_valid, iss_rd,
    input  a_ready, b_ready,
    input  busy, reg_write, rw_reg, wr_data
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for a single-write-port register file.
// Arbitrates round-robin between ALU results (a_*) and load data (b_*),
// registers the granted write onto reg_write/rw_reg/wr_data, and keeps a
// busy scoreboard of destination registers with write-backs outstanding.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   wb      : write-back bus (slave side), see regfile_wb_scheduler_if
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  regfile_wb_scheduler_if.slave   wb
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e              pri_q, pri_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rw_reg_q, rw_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              a_rdy;
  logic              b_rdy;
  logic              xfer;
  logic [ADDR_W-1:0] grant_rd;
  logic [DATA_W-1:0] grant_data;

  // Readies are the only combinational outputs; they are forced low during
  // reset so nothing handshakes while the state is being cleared.
  always_comb begin
    a_rdy = i_rst_n & wb.a_valid & (~wb.b_valid | (pri_q == PRI_A));
    b_rdy = i_rst_n & wb.b_valid & (~wb.a_valid | (pri_q == PRI_B));
    xfer  = a_rdy | b_rdy;
    grant_rd   = a_rdy ? wb.a_rd   : wb.b_rd;
    grant_data = a_rdy ? wb.a_data : wb.b_data;
  end

  // Priority pointer: always hands priority to the requester that was not
  // granted, even when it was not requesting.
  always_comb begin
    pri_d = pri_q;
    if (a_rdy) begin
      pri_d = PRI_B;
    end else if (b_rdy) begin
      pri_d = PRI_A;
    end
  end

  // Write port: index/data follow every transfer (including rd==0), but the
  // enable is suppressed for register 0.
  always_comb begin
    reg_write_d = xfer & (grant_rd != '0);
    rw_reg_d    = xfer ? grant_rd   : rw_reg_q;
    wr_data_d   = xfer ? grant_data : wr_data_q;
  end

  // Scoreboard: issue set takes precedence over write-back clear so a newly
  // issued producer of the same register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned n = 1; n < NREG; n++) begin
      if (wb.iss_valid && (wb.iss_rd == ADDR_W'(n))) begin
        busy_d[n] = 1'b1;
      end else if (xfer && (grant_rd == ADDR_W'(n))) begin
        busy_d[n] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pri_q       <= PRI_A;
      reg_write_q <= 1'b0;
      rw_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      pri_q       <= pri_d;
      reg_write_q <= reg_write_d;
      rw_reg_q    <= rw_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wb.a_ready   = a_rdy;
  assign wb.b_ready   = b_rdy;
  assign wb.reg_write = reg_write_q;
  assign wb.rw_reg    = rw_reg_q;
  assign wb.wr_data   = wr_data_q;
  assign wb.busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_wb_scheduler_if #(.DATA_W(32), .ADDR_W(5), .NREG(32)) wb ();

  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .wb      (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic        iv;
    logic [4:0]  ird;
    logic        exp_ar;
    logic        exp_br;
    logic        exp_we;
    logic [4:0]  exp_rw;
    logic [31:0] exp_wd;
    logic [31:0] exp_busy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ird);
    rst_n        = r;
    wb.a_valid   = av;
    wb.a_rd      = ard;
    wb.a_data    = ad;
    wb.b_valid   = bv;
    wb.b_rd      = brd;
    wb.b_data    = bd;
    wb.iss_valid = iv;
    wb.iss_rd    = ird;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] order [8];
    logic [4:0] ai;
    logic [4:0] bi;
    logic       ar;
    logic       br;
    checks = 0;
    errors = 0;

    //           rst   av    ard    adata           bv    brd    bdata         iv    ird    ar    br    we    rw     wd              busy
    vecs[0]  = '{1'b0, 1'b1, 5'd1,  32'h0000_00A1, 1'b1, 5'd2,  32'h0000_00B2, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd6,  32'h0000_0066, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd6,  32'h0000_0066, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 5'd6,  32'h0000_0066, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd6,  32'h0000_0066, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b1, 5'd2,  32'h0000_0022, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0033, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0033, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h0000_1234, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_1234, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_1234, 32'h0000_0080};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_1234, 32'h0000_0080};
    vecs[12] = vecs[11];
    vecs[13] = '{1'b1, 1'b1, 5'd7,  32'h0000_0077, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0077, 32'h0000_0000};
    vecs[14] = '{1'b1, 1'b1, 5'd7,  32'h0000_0070, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0070, 32'h0000_0080};
    vecs[15] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd7,  32'h0000_0071, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0071, 32'h0000_0200};
    vecs[16] = '{1'b0, 1'b1, 5'd4,  32'h0000_0044, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[17] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};

    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst_n, vecs[i].av, vecs[i].ard, vecs[i].adata,
            vecs[i].bv, vecs[i].brd, vecs[i].bdata, vecs[i].iv, vecs[i].ird);
      #3;
      chk($sformatf("v%0d a_ready", i), 32'(wb.a_ready), 32'(vecs[i].exp_ar));
      chk($sformatf("v%0d b_ready", i), 32'(wb.b_ready), 32'(vecs[i].exp_br));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d reg_write", i), 32'(wb.reg_write), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d rw_reg", i),    32'(wb.rw_reg),    32'(vecs[i].exp_rw));
      chk($sformatf("v%0d wr_data", i),   wb.wr_data,        vecs[i].exp_wd);
      chk($sformatf("v%0d busy", i),      wb.busy,           vecs[i].exp_busy);
    end

    // Sustained contention: each requester advances its rd only when accepted.
    order[0] = 5'd1; order[1] = 5'd9;  order[2] = 5'd2; order[3] = 5'd10;
    order[4] = 5'd3; order[5] = 5'd11; order[6] = 5'd4; order[7] = 5'd12;
    ai = 5'd0;
    bi = 5'd0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, (ai < 5'd4), 5'd1 + ai, 32'hC0DE_0000 | 32'(5'd1 + ai),
            (bi < 5'd4), 5'd9 + bi, 32'hC0DE_0000 | 32'(5'd9 + bi), 1'b0, '0);
      #3;
      ar = wb.a_ready;
      br = wb.b_ready;
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d reg_write", c), 32'(wb.reg_write), 32'd1);
      chk($sformatf("cont%0d rw_reg", c),    32'(wb.rw_reg),    32'(order[c]));
      chk($sformatf("cont%0d wr_data", c),   wb.wr_data,        32'hC0DE_0000 | 32'(order[c]));
      if (ar) ai = ai + 5'd1;
      if (br) bi = bi + 5'd1;
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("cont_end reg_write", 32'(wb.reg_write), 32'd0);
    chk("cont_end rw_reg",    32'(wb.rw_reg),    32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the single-write-port register file. It shares the one write port between two producers, ALU results and load data, using round-robin arbitration. It registers the selected write onto the register file's reg_write/rw_reg/wr_data inputs. It also keeps a 32-entry busy scoreboard so the issue stage can stall on pending destination registers. It sits between the execute/memory stages and the register file.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width
- NREG, 32, number of registers tracked by the scoreboard (2**ADDR_W)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- a_valid  in  1  ALU write-back request
- a_ready  out  1  ALU request accepted this cycle
- a_rd  in  ADDR_W  ALU destination register
- a_data  in  DATA_W  ALU result
- b_valid  in  1  load write-back request
- b_ready  out  1  load request accepted this cycle
- b_rd  in  ADDR_W  load destination register
- b_data  in  DATA_W  load data
- iss_valid  in  1  an instruction with a destination register issues this cycle
- iss_rd  in  ADDR_W  destination of the issuing instruction
- busy  out  NREG  scoreboard; bit n = register n has a write-back pending
- reg_write  out  1  register-file write enable
- rw_reg  out  ADDR_W  register-file write index
- wr_data  out  DATA_W  register-file write data

## Operation
- Handshake: a request transfers on a cycle where valid and ready are both 1. Requesters hold valid, rd and data stable until the transfer.
- The register file always accepts a write, so exactly one request is granted whenever at least one valid is high.
- Ready is combinational from valid and the priority pointer:
  - a_ready = a_valid & (~b_valid | pri==A)
  - b_ready = b_valid & (~a_valid | pri==B)
- Priority pointer pri is 1 bit. After each granted transfer, pri moves to the requester that was not granted. If only one requester was valid, pri still moves to the other requester. Reset value is A.
- Output register: on a transfer, next cycle reg_write=1 and rw_reg/wr_data hold the granted rd/data. With no transfer, next cycle reg_write=0 and rw_reg/wr_data hold their previous values.
- rd==0: the handshake completes normally, but reg_write stays 0 on the following cycle. Register 0 is never written.
- Scoreboard, per bit n, evaluated each edge:
  - set if iss_valid & iss_rd==n & n!=0
  - else cleared if a transfer with rd==n occurs this cycle
  - else held
  - If issue and transfer hit the same register in the same cycle, set wins: the new producer is outstanding.
- busy[0] is constant 0.
- busy reflects the scoreboard register directly, with no bypass. A register cleared at edge k reads not-busy from cycle k+1, the same cycle its value is being written into the register file.
- Clearing a bit that is already 0 has no effect and raises no error.

## Timing
- Reset (i_rst_n=0 sampled at an edge): reg_write=0, rw_reg=0, wr_data=0, busy=0, pri=A.
- a_ready and b_ready are 0 while i_rst_n=0.
- Any handshake, pending write or issue in flight during reset is discarded. There is no write to the register file on the cycle after reset deasserts.
- Latency: transfer at edge k → reg_write high during cycle k..k+1 → register file captures at edge k+1. That is 2 edges from request to architectural update.
- Throughput: one write per cycle sustained. With both requesters held valid, grants strictly alternate A,B,A,B.
- No combinational path from reg_write, rw_reg or wr_data back to the inputs.
- The only combinational paths are valid → ready.

## Test plan
- Reset: drive a_valid=1, b_valid=1, iss_valid=1 with i_rst_n=0 for 3 cycles → reg_write=0, busy=0, both readies 0; the first grant after release goes to A.
- Single write: a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle → a_ready=1; next cycle reg_write=1, rw_reg=5, wr_data=0xDEADBEEF; the cycle after, reg_write=0.
- Contention: both requesters valid continuously, A rd=1..4 and B rd=9..12 → write order 1,9,2,10,3,11,4,12 with no idle cycles.
- Register zero: b_valid=1, b_rd=0, b_data=0x1234 → b_ready=1; next cycle reg_write=0. Issuing iss_rd=0 leaves busy[0]=0.
- Scoreboard: issue rd=7 → busy[7]=1 next cycle; A writes rd=7 three cycles later → busy[7]=0 the following cycle.
- Scoreboard, simultaneous event: issue rd=7 and A write rd=7 in the same cycle → busy[7] stays 1.
